// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : img_pkg
//  Description : Shared definitions for the DRAM stream loader: default
//                address/pixel widths and the transfer state enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

    localparam int c_ADDR_W = 19;   // DRAM byte address width
    localparam int c_DATA_W = 8;    // pixel width

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_LOAD_FLUSH = 3'd2,
        ST_RD         = 3'd3,
        ST_CAP        = 3'd4,
        ST_OUT        = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : addr_gen
//  Description : Transfer index generator. Holds base address, length and the
//                byte index k; produces base+k (modulo 2^ADDR_W) and a flag
//                for the last byte of the transfer.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                i_load          - latch i_base/i_len and clear k
//                i_base, i_len   - command base address and byte count
//                i_inc           - advance k by one
//                o_addr          - base + k
//                o_last          - k equals length-1
//  Revision    : 1.0 - initial release
// ============================================================================
module addr_gen #(
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_len,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] c_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= '0;
            r_len  <= '0;
            r_k    <= '0;
        end else if (i_load) begin
            r_base <= i_base;
            r_len  <= i_len;
            r_k    <= '0;
        end else if (i_inc) begin
            r_k    <= r_k + c_ONE;
        end
    end

    // Sum truncated to ADDR_W bits so the address wraps from all-ones to 0.
    assign o_addr = r_base + r_k;
    assign o_last = (r_k == (r_len - c_ONE));

endmodule
`default_nettype wire

// File: rtl/dram_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : dram_stream_loader
//  Description : Moves a byte stream into DRAM (mode 0) or dumps a DRAM
//                region onto an output stream (mode 1).
//  Ports       : clk, rst_n                     - clock, async active-low reset
//                start, mode, base_addr, length - command (sampled in IDLE)
//                s_valid, s_data, s_ready       - input stream
//                m_valid, m_data, m_ready       - output stream
//                busy, done                     - status
//                dAddr, dram_wdata, MEM_WRITE,
//                dram_rdata                     - DRAM (1-cycle read latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_stream_loader
    import img_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] dAddr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic              MEM_WRITE,
    input  logic [DATA_W-1:0] dram_rdata
);

    state_t            r_state;
    state_t            w_next;

    logic              w_cmd;
    logic              w_accept;
    logic              w_take;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_m_data;

    assign w_cmd    = (r_state == ST_IDLE) && start;
    assign w_accept = (r_state == ST_LOAD) && s_valid;
    assign w_take   = (r_state == ST_OUT)  && m_ready;

    addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_cmd),
        .i_base (base_addr),
        .i_len  (length),
        .i_inc  (w_accept || w_take),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        w_next = ST_DONE;
                    end else if (mode) begin
                        w_next = ST_RD;
                    end else begin
                        w_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (s_valid && w_last) begin
                    w_next = ST_LOAD_FLUSH;
                end
            end
            ST_LOAD_FLUSH: w_next = ST_DONE;
            ST_RD:         w_next = ST_CAP;
            ST_CAP:        w_next = ST_OUT;
            ST_OUT: begin
                if (m_ready) begin
                    w_next = w_last ? ST_DONE : ST_RD;
                end
            end
            ST_DONE:       w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (r_state)
            ST_IDLE: busy    = 1'b0;
            ST_LOAD: s_ready = 1'b1;
            ST_OUT:  m_valid = 1'b1;
            ST_DONE: done    = 1'b1;
            default: ;
        endcase
    end

    // Writes are presented one cycle after acceptance; a pending write owns
    // the address bus, otherwise RD drives the read address. A write can
    // never be pending while in RD, so the two never collide.
    always_comb begin
        dAddr = '0;
        if (r_wr_en) begin
            dAddr = r_wr_addr;
        end else if (r_state == ST_RD) begin
            dAddr = w_addr;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_m_data  <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= w_addr;
                r_wr_data <= s_data;
            end
            // dram_rdata is valid in CAP for the address presented in RD.
            if (r_state == ST_CAP) begin
                r_m_data <= dram_rdata;
            end
        end
    end

    assign MEM_WRITE  = r_wr_en;
    assign dram_wdata = r_wr_data;
    assign m_data     = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_dram_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_stream_loader
//  Description : Scoreboard bench for dram_stream_loader. Stimulus pushes the
//                expected DRAM writes and stream bytes into queues; monitors
//                pop and compare whenever the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_stream_loader;

    localparam int c_AW = 19;
    localparam int c_DW = 8;

    typedef struct {
        logic [c_AW-1:0] a;
        logic [c_DW-1:0] d;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            mode = 1'b0;
    logic [c_AW-1:0] base_addr = '0;
    logic [c_AW-1:0] length = '0;
    logic            s_valid = 1'b0;
    logic [c_DW-1:0] s_data = '0;
    logic            s_ready;
    logic            m_valid;
    logic [c_DW-1:0] m_data;
    logic            m_ready = 1'b0;
    logic            busy;
    logic            done;
    logic [c_AW-1:0] dAddr;
    logic [c_DW-1:0] dram_wdata;
    logic            MEM_WRITE;
    logic [c_DW-1:0] dram_rdata = '0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int stall_cnt = 0;

    wr_t             exp_wr[$];
    logic [c_DW-1:0] exp_out[$];

    logic [c_DW-1:0] mem [0:(1<<c_AW)-1];

    dram_stream_loader #(
        .ADDR_W (c_AW),
        .DATA_W (c_DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .base_addr  (base_addr),
        .length     (length),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .dAddr      (dAddr),
        .dram_wdata (dram_wdata),
        .MEM_WRITE  (MEM_WRITE),
        .dram_rdata (dram_rdata)
    );

    always #5 clk = ~clk;

    // DRAM model: write on strobe, read data valid the cycle after dAddr.
    always @(posedge clk) begin
        if (MEM_WRITE) mem[dAddr] <= dram_wdata;
        dram_rdata <= mem[dAddr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // ---------------- monitors ----------------
    logic            prev_stall = 1'b0;
    logic [c_DW-1:0] prev_data  = '0;

    always @(negedge clk) begin
        wr_t e;
        logic [c_DW-1:0] x;
        if (done === 1'b1) done_cnt++;

        if (MEM_WRITE === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0d data=%0d required none",
                         dAddr, dram_wdata);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(dAddr), 32'(e.a));
                chk("wr_data", 32'(dram_wdata), 32'(e.d));
            end
        end

        if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'(prev_data));
        end

        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_out.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=%0d required none", m_data);
            end else begin
                x = exp_out.pop_front();
                chk("out_data", 32'(m_data), 32'(x));
            end
        end

        prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
        prev_data  = m_data;
        if (prev_stall) stall_cnt++;
    end

    // ---------------- stimulus helpers (called at #1 after an edge) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [c_AW-1:0] b, input logic [c_AW-1:0] l, input logic m);
        base_addr = b;
        length    = l;
        mode      = m;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        exp_wr.push_back('{a: a, d: d});
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", nm);
        end
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        int n;
        logic [c_DW-1:0] gb [4];
        int              gg [4];
        gb[0] = 8'd1; gb[1] = 8'd2; gb[2] = 8'd3; gb[3] = 8'd4;
        gg[0] = 0;    gg[1] = 2;    gg[2] = 0;    gg[3] = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd0);
        chk("rst_daddr", 32'(dAddr), 32'd0);
        rst_n = 1'b1;
        step();

        // Load base=10, length=3, back-to-back bytes
        d0 = done_cnt;
        do_start(19'd10, 19'd3, 1'b0);
        chk("load_sready", 32'(s_ready), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        send_byte(19'd10, 8'd255);
        s_valid = 1'b1;
        send_byte(19'd11, 8'd5);
        s_valid = 1'b1;
        send_byte(19'd12, 8'd7);
        chk("flush_sready", 32'(s_ready), 32'd0);
        chk("flush_write", 32'(MEM_WRITE), 32'd1);
        chk("flush_addr", 32'(dAddr), 32'd12);
        chk("flush_done", 32'(done), 32'd0);
        step();
        chk("load_done_pulse", 32'(done), 32'd1);
        step();
        chk("load_done_end", 32'(done), 32'd0);
        chk("load_idle", 32'(busy), 32'd0);
        chk("load_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Load with s_valid gaps: base=20, length=4
        do_start(19'd20, 19'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat (gg[i]) step();
            send_byte(19'd20 + 19'(i), gb[i]);
        end
        wait_done("gap");

        // Dump base=10, length=2 with m_ready toggling
        exp_out.push_back(8'd255);
        exp_out.push_back(8'd5);
        stall_cnt = 0;
        do_start(19'd10, 19'd2, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 80) begin
            m_ready = ((n % 4) == 3);
            step();
            n++;
        end
        m_ready = 1'b0;
        chk("dump_finished", 32'(done), 32'd1);
        chk("dump_stalled", 32'(stall_cnt > 0), 32'd1);
        step();

        // Wrap-around load at the top of the address space
        do_start(19'h7FFFF, 19'd2, 1'b0);
        send_byte(19'h7FFFF, 8'hAA);
        s_valid = 1'b1;
        send_byte(19'h00000, 8'hBB);
        wait_done("wrap");

        // Wrap-around dump with m_ready held: 3 cycles per byte
        exp_out.push_back(8'hAA);
        exp_out.push_back(8'hBB);
        m_ready = 1'b1;
        do_start(19'h7FFFF, 19'd2, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("dump_cycles", 32'(n), 32'd6);
        m_ready = 1'b0;
        step();

        // Zero-length command
        d0 = done_cnt;
        do_start(19'd50, 19'd0, 1'b0);
        chk("zero_busy", 32'(busy), 32'd1);
        chk("zero_done", 32'(done), 32'd1);
        step();
        chk("zero_busy_end", 32'(busy), 32'd0);
        chk("zero_done_end", 32'(done), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Reset mid-load after 2 of 5 bytes, with an ignored start while busy
        d0 = done_cnt;
        do_start(19'd100, 19'd5, 1'b0);
        send_byte(19'd100, 8'd11);
        base_addr = 19'd300;
        length    = 19'd0;
        mode      = 1'b1;
        start     = 1'b1;
        send_byte(19'd101, 8'd22);
        start     = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_sready", 32'(s_ready), 32'd0);
        chk("abort_mvalid", 32'(m_valid), 32'd0);
        chk("abort_mdata", 32'(m_data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_daddr", 32'(dAddr), 32'd0);
        chk("abort_wdata", 32'(dram_wdata), 32'd0);
        chk("abort_write", 32'(MEM_WRITE), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_mem0", 32'(mem[100]), 32'd11);
        chk("abort_mem1", 32'(mem[101]), 32'd22);

        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("out_queue_empty", 32'(exp_out.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_stream_loader.md
DRAM_STREAM_LOADER -- requirements
Module: dram_stream_loader

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 19, DRAM byte address width; DATA_W, default 8, pixel width.
REQ-002 Clock and reset SHALL be: clk  in  1  single clock, all state on rising edge; rst_n  in  1  asynchronous, active-low reset.
REQ-003 Command ports SHALL be: start  in  1  begin transfer; mode  in  1  0=load stream to DRAM, 1=dump DRAM to stream; base_addr  in  ADDR_W  first address; length  in  ADDR_W  byte count.
REQ-004 Input stream ports SHALL be: s_valid  in  1; s_data  in  DATA_W; s_ready  out  1.
REQ-005 Output stream ports SHALL be: m_valid  out  1; m_data  out  DATA_W; m_ready  in  1.
REQ-006 Status ports SHALL be: busy  out  1  state not IDLE; done  out  1  one-cycle completion pulse.
REQ-007 DRAM ports SHALL be: dAddr  out  ADDR_W; dram_wdata  out  DATA_W; MEM_WRITE  out  1  write strobe; dram_rdata  in  DATA_W  read data, valid the cycle after dAddr is presented.

Function
REQ-008 States SHALL be IDLE, LOAD, LOAD_FLUSH, RD, CAP, OUT, DONE.
REQ-009 In IDLE, start=1 SHALL latch base_addr, length, mode and clear index k to 0; go to DONE if length=0, else LOAD (mode 0) or RD (mode 1).
REQ-010 start while busy=1 SHALL be ignored; command inputs are sampled only in IDLE.
REQ-011 LOAD: s_ready=1; each edge with s_valid=1 accepts s_data; no acceptance when s_valid=0.
REQ-012 Accepted byte k SHALL appear next cycle as MEM_WRITE=1, dAddr=base+k, dram_wdata=byte; MEM_WRITE=0 in every other cycle.
REQ-013 Address arithmetic SHALL be modulo 2^ADDR_W; base+k wraps from all-ones to 0 without error.
REQ-014 Acceptance of byte length-1 SHALL move to LOAD_FLUSH (s_ready=0, final write presented), then DONE.
REQ-015 RD: dAddr=base+k, MEM_WRITE=0; next cycle CAP; CAP registers dram_rdata into m_data, then OUT.
REQ-016 OUT: m_valid=1, m_data stable until m_ready=1; on handshake k increments, next state RD, or DONE if k was length-1.
REQ-017 DONE SHALL last exactly one cycle with done=1, then IDLE; done=0 in all other states.
REQ-018 s_ready SHALL be 0 outside LOAD; m_valid SHALL be 0 outside OUT.
REQ-019 Dump throughput SHALL be one byte per 3 cycles when m_ready is held 1; load throughput one byte per cycle.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE, k=0, and all outputs 0 (s_ready, m_valid, m_data, busy, done, dAddr, dram_wdata, MEM_WRITE).
REQ-021 Reset mid-transfer SHALL abort with no further MEM_WRITE and no done pulse; bytes already written remain in DRAM.

Structure
REQ-022 ADDR_W, DATA_W defaults and the state enumeration SHALL live in shared package img_pkg.
REQ-023 Address index/offset generation (k counter, base+k, last-byte compare) SHALL be sub-module addr_gen.

Verification
REQ-024 Load base=10, length=3, bytes 255,5,7 with s_valid held 1 -> writes at 10,11,12 on consecutive cycles, done 2 cycles after third acceptance.
REQ-025 Load with s_valid gaps -> MEM_WRITE only for accepted bytes, addresses contiguous, no duplicate writes.
REQ-026 Dump base=10, length=2 after REQ-024 load, m_ready toggled -> m_data 255 then 5, each held stable while m_valid=1 and m_ready=0.
REQ-027 Load base=2^19-1, length=2 -> writes at 524287 then 0.
REQ-028 start with length=0 -> done pulse next cycle, zero MEM_WRITE, busy high for exactly one cycle.
REQ-029 rst_n pulled low after 2 of 5 load bytes; start pulsed during busy -> outputs 0 immediately, no done, ignored start causes no relatch.
